full_adder_signed_16bit: RTL and testbench
==========================================

Name: full_adder_signed_16bit

Overview:
- Registered two's-complement adder for the ALU datapath.
- Computes A + B + Cin over WIDTH bits and reports the sum, unsigned carry-out and signed overflow.
- Built as a ripple chain of 1-bit full-adder cells.
- Outputs are registered one clock after the operands are presented; feeds the ALU result mux.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, two's complement.
- B  input  WIDTH  operand B, two's complement.
- Cin  input  1  carry-in into bit 0.
- S  output  WIDTH  registered sum, A + B + Cin mod 2^WIDTH.
- Cout  output  1  registered carry out of the MSB (unsigned carry).
- Overflow  output  1  registered signed overflow flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n = 0, S = 0, Cout = 0 and Overflow = 0, immediately and independent of clk. These values hold until the first rising clk edge after rst_n deasserts.
- Datapath:
  - c[0] = Cin.
  - For each bit i: s[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])).
  - Raw Cout = c[WIDTH].
  - Raw Overflow = c[WIDTH] ^ c[WIDTH-1], equivalently (A[MSB] == B[MSB]) && (s[MSB] != A[MSB]).
- Latency: exactly 1 cycle. Operands applied before rising edge n appear on S/Cout/Overflow after edge n. No handshake; every edge captures a new result.
- The output registers are the only state; there is no FSM.
- Wrap-around: the sum is always modulo 2^WIDTH. Cout and Overflow are independent, and all four combinations are legal:
  - 0xFFFF + 0x0001 gives S = 0, Cout = 1, Overflow = 0.
  - 0x7FFF + 0x0001 gives S = 0x8000, Cout = 0, Overflow = 1.
- Cin = 1 participates in overflow and carry exactly like an extra LSB addend. For example, 0x7FFF + 0x0000 + Cin 1 gives Overflow = 1.
- Reset asserted mid-operation: outputs clear at once and the in-flight result is discarded.
- No X propagation from Cin: Cin is always a valid input.

Optional Feature:
- Macro: FULL_ADDER_SIGNED_SATURATE_EN.
- When defined, S saturates on signed overflow:
  - Positive overflow (both operands' MSB = 0) gives S = 0x7FFF, i.e. {0, all ones}.
  - Negative overflow (both operands' MSB = 1) gives S = 0x8000, i.e. {1, zeros}.
  - Cout and Overflow still report the raw, unsaturated flags.
- When undefined, S is always the wrapped sum and no saturation logic is synthesised.

Decomposition:
- Shared package alu_pkg holds:
  - the width constant ALU_WIDTH = 16;
  - the saturation constants SAT_MAX and SAT_MIN;
  - a typedef for a WIDTH-bit word.
- One natural sub-module: full_adder_bit, a 1-bit combinational cell (a, b, cin -> s, cout). It is instantiated WIDTH times in a generate loop inside the top.

Test Plan:
- Reset: rst_n = 0 with A = B = 0xFFFF, Cin = 1 -> S = 0, Cout = 0, Overflow = 0 with no clock edge; release, then 0x0001 + 0x0001 -> one cycle later S = 0x0002, Cout = 0, Overflow = 0.
- Negative + negative with signed overflow: 0x8030 + 0x80E0, Cin = 0 -> S = 0x0110, Cout = 1, Overflow = 1 (with SATURATE_EN: S = 0x8000).
- Mixed signs: 0x8000 + 0x0400 -> S = 0x8400, Cout = 0, Overflow = 0.
- Positive + positive overflow: 0x4001 + 0x4003 -> S = 0x8004, Cout = 0, Overflow = 1 (SATURATE_EN: S = 0x7FFF).
- Boundaries:
  - 0x7FFF + 0x0001 -> S = 0x8000, Overflow = 1, Cout = 0.
  - 0xFFFF + 0x0001 -> S = 0x0000, Cout = 1, Overflow = 0.
  - 0xFFFF + 0x0000 + Cin = 1 -> S = 0x0000, Cout = 1, Overflow = 0.
- Back-to-back and reset mid-stream: change operands every cycle and check each result lags by exactly one edge; assert rst_n low between edges -> outputs clear immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: word width, the word type and the
// saturation limits used by the adder when FULL_ADDER_SIGNED_SATURATE_EN
// is defined.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef logic [ALU_WIDTH-1:0] word_t;

  // Most positive and most negative two's-complement words.
  localparam word_t SAT_MAX = {1'b0, {(ALU_WIDTH-1){1'b1}}};
  localparam word_t SAT_MIN = {1'b1, {(ALU_WIDTH-1){1'b0}}};

endpackage : alu_pkg

// File: rtl/full_adder_bit.sv
// One-bit combinational full-adder cell, the building block of the ripple chain.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic prop;

  // Propagate term is shared by the sum and the carry.
  always_comb begin
    prop   = a_i ^ b_i;
    s_o    = prop ^ cin_i;
    cout_o = (a_i & b_i) | (cin_i & prop);
  end

endmodule : full_adder_bit

// File: rtl/full_adder_signed_16bit.sv
// Registered two's-complement ripple-carry adder: S = A + B + Cin with
// unsigned carry-out and signed overflow, one cycle of latency.
// Optional build macro FULL_ADDER_SIGNED_SATURATE_EN clamps S on signed
// overflow; Cout and Overflow always report the raw flags.
module full_adder_signed_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Overflow
);

  logic [WIDTH-1:0] sum_raw;
  logic             carry_out_msb;
  logic             carry_into_msb;
  logic             ovf_raw;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  // Ripple chain. Each stage keeps its own carry nets so the chain is a
  // set of distinct signals rather than one self-referencing vector.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic c_in;
    logic c_out;
    logic s_bit;

    if (gi == 0) begin : g_lsb
      assign c_in = Cin;
    end else begin : g_chain
      assign c_in = g_bit[gi-1].c_out;
    end

    full_adder_bit u_cell (
      .a_i   (A[gi]),
      .b_i   (B[gi]),
      .cin_i (c_in),
      .s_o   (s_bit),
      .cout_o(c_out)
    );

    assign sum_raw[gi] = s_bit;
  end

  assign carry_out_msb  = g_bit[WIDTH-1].c_out;
  assign carry_into_msb = g_bit[WIDTH-1].c_in;

`ifdef FULL_ADDER_SIGNED_SATURATE_EN
  // Width-generic forms of alu_pkg::SAT_MAX / SAT_MIN.
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Next-state: raw flags, sum clamped toward the sign of the operands on overflow.
  always_comb begin
    ovf_raw = carry_out_msb ^ carry_into_msb;
    cout_d  = carry_out_msb;
    ovf_d   = ovf_raw;
    sum_d   = sum_raw;
    if (ovf_raw) begin
      // Overflow only happens with equal operand signs, so A's MSB picks the rail.
      sum_d = A[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  // Next-state: wrapped sum and raw flags.
  always_comb begin
    ovf_raw = carry_out_msb ^ carry_into_msb;
    cout_d  = carry_out_msb;
    ovf_d   = ovf_raw;
    sum_d   = sum_raw;
  end
`endif

  // Output registers; asynchronous reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign S        = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;

endmodule : full_adder_signed_16bit

// File: tb/tb_full_adder_signed_16bit.sv
// Table-driven bench for full_adder_signed_16bit (WIDTH = 16).
module tb_full_adder_signed_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] S;
  logic        Cout;
  logic        Overflow;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s_wrap;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  full_adder_signed_16bit #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .S       (S),
    .Cout    (Cout),
    .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected S for a vector given the build configuration.
  function automatic logic [15:0] exp_s(input vec_t v);
    logic [15:0] r;
    r = v.s_wrap;
`ifdef FULL_ADDER_SIGNED_SATURATE_EN
    if (v.ovf) r = v.a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] s_e,
                       input logic c_e, input logic o_e);
    n_checks++;
    if (S !== s_e) begin
      n_fail++;
      $display("FAIL %s S: got %h expected %h", name, S, s_e);
    end
    n_checks++;
    if (Cout !== c_e) begin
      n_fail++;
      $display("FAIL %s Cout: got %b expected %b", name, Cout, c_e);
    end
    n_checks++;
    if (Overflow !== o_e) begin
      n_fail++;
      $display("FAIL %s Overflow: got %b expected %b", name, Overflow, o_e);
    end
    $display("%s: S=%h Cout=%b Ovf=%b (exp %h %b %b)", name, S, Cout, Overflow, s_e, c_e, o_e);
  endtask

  task automatic drive(input vec_t v);
    A   = v.a;
    B   = v.b;
    Cin = v.cin;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            a        b        cin   s_wrap   cout  ovf
    vecs[0]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1]  = '{16'h8030, 16'h80E0, 1'b0, 16'h0110, 1'b1, 1'b1};
    vecs[2]  = '{16'h8000, 16'h0400, 1'b0, 16'h8400, 1'b0, 1'b0};
    vecs[3]  = '{16'h4001, 16'h4003, 1'b0, 16'h8004, 1'b0, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[8]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[11] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    // Reset with all-ones operands and no clock edge yet (first posedge at 5).
    rst_n = 1'b1;
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_held", 16'h0000, 1'b0, 1'b0);

    // Release at a falling edge; first vector then appears after one rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_release", 16'h0000, 1'b0, 1'b0);

    // Table: one vector per transaction, checked just after the capturing edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), exp_s(vecs[i]), vecs[i].cout, vecs[i].ovf);
    end

    // Back-to-back: new operands each cycle; outputs must still show the
    // previous result just before the edge and the new one after it.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #4;
      if (i > 0)
        check($sformatf("b2b_hold%0d", i), exp_s(vecs[i-1]), vecs[i-1].cout, vecs[i-1].ovf);
      @(posedge clk); #1;
      check($sformatf("b2b_new%0d", i), exp_s(vecs[i]), vecs[i].cout, vecs[i].ovf);
    end

    // Reset mid-stream between edges: outputs clear at once, in-flight result dropped.
    @(negedge clk);
    drive(vecs[9]);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_async", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mid_reset_held", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(vecs[3]);
    @(posedge clk); #1;
    check("after_mid_reset", exp_s(vecs[3]), vecs[3].cout, vecs[3].ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_full_adder_signed_16bit
